// File: rtl/id_exe_stage_reg.sv
//------------------------------------------------------------------------------
// Module   : id_exe_stage_reg
// Brief    : ID->EXE pipeline register with hold, flush and bubble handling,
//            plus the architectural {Z,C,N,V} status register feeding the ALU.
//            Optional macro ID_EXE_FORWARDING_EN registers exe_src1/exe_src2.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_exe_stage_reg #(
    parameter int         DATA_W     = 32,
    parameter logic [3:0] STATUS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              bubble,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [3:0]        id_exe_cmd,
    input  logic [5:0]        id_ctrl,
    input  logic [11:0]       id_shift_op,
    input  logic [23:0]       id_imm24,
    input  logic [3:0]        id_dest,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic [3:0]        alu_status,
    output logic              exe_valid,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic [3:0]        exe_cmd,
    output logic [5:0]        exe_ctrl,
    output logic [11:0]       exe_shift_op,
    output logic [23:0]       exe_imm24,
    output logic [3:0]        exe_dest,
    output logic [3:0]        exe_src1,
    output logic [3:0]        exe_src2,
    output logic [3:0]        status,
    output logic              status_c
);

    localparam logic [3:0] c_NOP_CMD  = 4'b0000;
    localparam logic [5:0] c_NOP_CTRL = 6'b000000;
    localparam int         c_CTRL_S   = 1;
    localparam int         c_STAT_C   = 2;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_val_rn;
    logic [DATA_W-1:0] r_val_rm;
    logic [3:0]        r_cmd;
    logic [5:0]        r_ctrl;
    logic [11:0]       r_shift_op;
    logic [23:0]       r_imm24;
    logic [3:0]        r_dest;
    logic [3:0]        r_status;

    logic w_kill;
    logic w_status_we;

    assign w_kill      = flush | bubble;
    // Capture keys off the instruction leaving EXE, so kill does not gate it.
    assign w_status_we = r_valid & r_ctrl[c_CTRL_S];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_val_rn   <= '0;
            r_val_rm   <= '0;
            r_cmd      <= c_NOP_CMD;
            r_ctrl     <= c_NOP_CTRL;
            r_shift_op <= '0;
            r_imm24    <= '0;
            r_dest     <= '0;
            r_status   <= STATUS_RST;
        end else if (!hold) begin
            r_valid    <= ~w_kill;
            r_cmd      <= w_kill ? c_NOP_CMD  : id_exe_cmd;
            r_ctrl     <= w_kill ? c_NOP_CTRL : id_ctrl;
            r_pc       <= id_pc;
            r_val_rn   <= id_val_rn;
            r_val_rm   <= id_val_rm;
            r_shift_op <= id_shift_op;
            r_imm24    <= id_imm24;
            r_dest     <= id_dest;
            if (w_status_we) begin
                r_status <= alu_status;
            end
        end
    end

`ifdef ID_EXE_FORWARDING_EN
    logic [3:0] r_src1;
    logic [3:0] r_src2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (!hold) begin
            r_src1 <= id_src1;
            r_src2 <= id_src2;
        end
    end

    assign exe_src1 = r_src1;
    assign exe_src2 = r_src2;
`else
    logic w_unused_src;

    assign w_unused_src = ^{id_src1, id_src2};
    assign exe_src1     = 4'b0000;
    assign exe_src2     = 4'b0000;
`endif

    assign exe_valid    = r_valid;
    assign exe_pc       = r_pc;
    assign exe_val_rn   = r_val_rn;
    assign exe_val_rm   = r_val_rm;
    assign exe_cmd      = r_cmd;
    assign exe_ctrl     = r_ctrl;
    assign exe_shift_op = r_shift_op;
    assign exe_imm24    = r_imm24;
    assign exe_dest     = r_dest;
    assign status       = r_status;
    assign status_c     = r_status[c_STAT_C];

endmodule

`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_id_exe_stage_reg
// Brief    : Scoreboard bench for id_exe_stage_reg: directed test-plan cycles
//            followed by randomized control/data, checked against a model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_exe_stage_reg;

    localparam int         DATA_W     = 32;
    localparam logic [3:0] STATUS_RST = 4'b0000;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rn;
        logic [DATA_W-1:0] rm;
        logic [3:0]        cmd;
        logic [5:0]        ctrl;
        logic [11:0]       shift_op;
        logic [23:0]       imm24;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [3:0]        status;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, hold, flush, bubble;
    logic [DATA_W-1:0] id_pc, id_val_rn, id_val_rm;
    logic [3:0]        id_exe_cmd, id_dest, id_src1, id_src2, alu_status;
    logic [5:0]        id_ctrl;
    logic [11:0]       id_shift_op;
    logic [23:0]       id_imm24;
    logic              exe_valid, status_c;
    logic [DATA_W-1:0] exe_pc, exe_val_rn, exe_val_rm;
    logic [3:0]        exe_cmd, exe_dest, exe_src1, exe_src2, status;
    logic [5:0]        exe_ctrl;
    logic [11:0]       exe_shift_op;
    logic [23:0]       exe_imm24;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t model;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.DATA_W(DATA_W), .STATUS_RST(STATUS_RST)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .bubble(bubble),
        .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
        .id_exe_cmd(id_exe_cmd), .id_ctrl(id_ctrl), .id_shift_op(id_shift_op),
        .id_imm24(id_imm24), .id_dest(id_dest), .id_src1(id_src1),
        .id_src2(id_src2), .alu_status(alu_status),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_val_rn(exe_val_rn),
        .exe_val_rm(exe_val_rm), .exe_cmd(exe_cmd), .exe_ctrl(exe_ctrl),
        .exe_shift_op(exe_shift_op), .exe_imm24(exe_imm24), .exe_dest(exe_dest),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .status(status),
        .status_c(status_c)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic rand_data();
        id_pc       = $urandom;
        id_val_rn   = $urandom;
        id_val_rm   = $urandom;
        id_exe_cmd  = 4'($urandom);
        id_ctrl     = 6'($urandom);
        id_shift_op = 12'($urandom);
        id_imm24    = 24'($urandom);
        id_dest     = 4'($urandom);
        id_src1     = 4'($urandom);
        id_src2     = 4'($urandom);
        alu_status  = 4'($urandom);
    endtask

    // Reference: the next EXE contents follow from this cycle's inputs and
    // the current model contents, then go onto the scoreboard.
    task automatic drive(input logic r, input logic h, input logic f, input logic b);
        logic capture;
        logic kill;
        rst = r; hold = h; flush = f; bubble = b;
        capture = model.valid && model.ctrl[1];
        kill    = f || b;
        if (r) begin
            model        = '0;
            model.status = STATUS_RST;
        end else if (!h) begin
            if (capture) model.status = alu_status;
            model.valid    = !kill;
            model.cmd      = kill ? 4'd0 : id_exe_cmd;
            model.ctrl     = kill ? 6'd0 : id_ctrl;
            model.pc       = id_pc;
            model.rn       = id_val_rn;
            model.rm       = id_val_rm;
            model.shift_op = id_shift_op;
            model.imm24    = id_imm24;
            model.dest     = id_dest;
`ifdef ID_EXE_FORWARDING_EN
            model.src1     = id_src1;
            model.src2     = id_src2;
`else
            model.src1     = 4'd0;
            model.src2     = 4'd0;
`endif
        end
        sb_q.push_back(model);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one registered result appears after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("exe_valid", 128'(exe_valid), 128'(e.valid));
                check("exe_cmd",   128'(exe_cmd),   128'(e.cmd));
                check("exe_ctrl",  128'(exe_ctrl),  128'(e.ctrl));
                check("status",    128'(status),    128'(e.status));
                check("status_c",  128'(status_c),  128'(e.status[2]));
                check("exe_src",   128'({exe_src1, exe_src2}), 128'({e.src1, e.src2}));
                // Data fields are don't-care after kill; compare them on real instructions.
                if (e.valid || rst) begin
                    check("exe_data", {exe_pc, exe_val_rn, exe_val_rm, exe_dest},
                          {e.pc, e.rn, e.rm, e.dest});
                    check("exe_sh_imm", 128'({exe_shift_op, exe_imm24}),
                          128'({e.shift_op, e.imm24}));
                end
            end
        end
    end

    initial begin
        model = '0;
        rst = 1'b1; hold = 1'b0; flush = 1'b0; bubble = 1'b0;
        rand_data();
        @(posedge clk);
        #2;
        // Reset with nonzero ID inputs.
        rand_data(); id_exe_cmd = 4'hF; id_ctrl = 6'h3F; id_val_rn = 32'hDEADBEEF;
        drive(1, 0, 0, 0);
        // Load, then S-instruction capturing status 0100.
        rand_data(); id_exe_cmd = 4'b0010; id_val_rn = 32'd5; id_ctrl = 6'b100010;
        drive(0, 0, 0, 0);
        rand_data(); id_ctrl = 6'b100000; alu_status = 4'b0100;
        drive(0, 0, 0, 0);
        // s=0 instruction in EXE: status must not change.
        rand_data(); id_ctrl = 6'b100010; alu_status = 4'b1111;
        drive(0, 0, 0, 0);
        // hold+flush: everything frozen, no capture although s=1 is in EXE.
        rand_data(); alu_status = 4'b0001;
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 1);
        // Flush with S-instruction in EXE: status=1000 and valid=0.
        rand_data(); alu_status = 4'b1000;
        drive(0, 0, 1, 0);
        rand_data(); id_ctrl = 6'b000010;
        drive(0, 0, 0, 0);
        rand_data(); alu_status = 4'b0110;
        drive(0, 0, 0, 1);
        rand_data(); id_src1 = 4'd7;
        drive(0, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            rand_data();
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end
        rst = 1'b0; hold = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

ID→EXE pipeline boundary of the ARM-subset core, directly upstream of the ALU. It captures decoded operands and control from the ID stage and presents them to the execute stage: `exe_val_rn`/Val2 source to `in1`/`in2`, `exe_cmd` to `EXE_Command`. It also owns the architectural status register {Z,C,N,V}. That register supplies `C` to the ALU and captures the ALU's `status` output for S-flagged instructions. The block handles stall (hold), branch flush and hazard bubble insertion.

## Interface
Parameters:
- `DATA_W`, 32, width of PC and register operands
- `STATUS_RST`, 4'b0000, reset value of status register {Z,C,N,V}

Ports:
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `hold` in 1: memory stall; freezes all state including the status register
- `flush` in 1: branch taken in EXE; the incoming ID instruction is killed
- `bubble` in 1: hazard detected; inserts a NOP in place of the ID instruction
- `id_pc` in DATA_W: PC+4 of the ID instruction
- `id_val_rn`, `id_val_rm` in DATA_W: register-file read data
- `id_exe_cmd` in 4: ALU command encoding
- `id_ctrl` in 6: {wb_en, mem_r, mem_w, b, s, imm}
- `id_shift_op` in 12: shifter operand
- `id_imm24` in 24: signed branch offset
- `id_dest`, `id_src1`, `id_src2` in 4: register indices
- `alu_status` in 4: ALU `status` {Z,C,N,V} of the instruction currently in EXE
- `exe_valid` out 1: EXE slot holds a real instruction
- `exe_pc`, `exe_val_rn`, `exe_val_rm` out DATA_W: registered copies of the corresponding ID inputs
- `exe_cmd` out 4, `exe_ctrl` out 6, `exe_shift_op` out 12, `exe_imm24` out 24, `exe_dest` out 4: registered copies of the corresponding ID inputs
- `exe_src1`, `exe_src2` out 4: registered sources (see Configuration)
- `status` out 4: architectural {Z,C,N,V}
- `status_c` out 1: `status[2]`, wired to the ALU `C` input

## Operation
- Per-edge priority: `rst` > `hold` > `flush` > `bubble` > load.
- `rst`:
  - all `exe_*` outputs become 0, including `exe_valid` and `exe_cmd` (4'b0000, which the ALU maps to result 0).
  - `status` becomes STATUS_RST.
- `hold`: every register retains its value; no status capture.
- `flush` or `bubble` (without `hold`):
  - `exe_valid`, `exe_ctrl` and `exe_cmd` become 0.
  - Data fields (pc, vals, shift_op, imm24, dest, src) still load from ID; they are don't-care.
- Load: all `exe_*` take the ID inputs and `exe_valid` becomes 1.
- Status capture: on an edge with `!rst && !hold && exe_valid && exe_ctrl[1]` (s bit), `status <= alu_status`. Otherwise `status` holds.
- Status capture uses the instruction *leaving* EXE. It is therefore independent of `flush`/`bubble`, which affect only the instruction entering.
- A flush coinciding with an S-flagged instruction in EXE: status updates and the ID instruction is killed.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Latency: 1 cycle from ID inputs to `exe_*` outputs.
- `status`/`status_c` change on the edge that ends the S-instruction's EXE cycle. The next instruction's ALU sees the new C in the same cycle it enters EXE (back-to-back ADDS→ADC correct).
- `hold` asserted for N cycles: outputs stable for N cycles; the first non-hold edge applies normal priority.
- Reset mid-stream overrides `hold`/`flush`; the first load is on the edge after `rst` deasserts.
- `status_c` is combinational from the status register only; there is no path from `alu_status`.

## Configuration
- `ID_EXE_FORWARDING_EN`:
  - Defined: `exe_src1`/`exe_src2` are registered like the other data fields, for the forwarding unit.
  - Undefined: no flops; both outputs are tied to 4'b0000.

## Test plan
- Reset: assert `rst` with nonzero ID inputs → next cycle all `exe_*`=0, `exe_valid`=0, `status`=4'b0000.
- Load: `id_exe_cmd`=4'b0010, `id_val_rn`=5, `id_ctrl`=6'b100010 → after 1 edge `exe_cmd`=4'b0010, `exe_val_rn`=5, `exe_valid`=1.
- Status: S-flagged instruction in EXE, `alu_status`=4'b0100 → next edge `status`=4'b0100, `status_c`=1. Same with s=0 → `status` unchanged.
- Flush vs bubble vs hold: `hold`+`flush` together → all outputs held. `flush` alone → `exe_valid`=0, `exe_ctrl`=0, `exe_cmd`=0. `bubble` alone → same result.
- Flush with S-instruction in EXE, `alu_status`=4'b1000 → `status`=4'b1000 and `exe_valid`=0.
- Macro: with `ID_EXE_FORWARDING_EN`, `id_src1`=4'd7 → `exe_src1`=7 after 1 edge. Without the macro → `exe_src1`=0.
